// File: rtl/bus_transceiver_reg.sv
// rtl/bus_transceiver_reg.sv - registered bidirectional A/B bus transceiver with turnaround FSM
module bus_transceiver_reg #(
  parameter int WIDTH      = 8,
  parameter int TURNAROUND = 1,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  inout  wire  [WIDTH-1:0] A,
  inout  wire  [WIDTH-1:0] B,
  input  logic             OE_n,
  input  logic             DIR,
  input  logic             CAP_A,
  input  logic             CAP_B,
  input  logic             SAB,
  input  logic             SBA,
  output logic [1:0]       state,
  output logic             a_drive,
  output logic             b_drive
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRIVE_AB = 2'd1,
    DRIVE_BA = 2'd2,
    TURN     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURNAROUND - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q, state_d, dir_state;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reg_a, reg_b;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_state = DIR ? DRIVE_AB : DRIVE_BA;
    if (OE_n) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE:     state_d = dir_state;
        DRIVE_AB: if (!DIR) begin
          state_d = TURN;
          cnt_d   = TURN_LOAD;
        end
        DRIVE_BA: if (DIR) begin
          state_d = TURN;
          cnt_d   = TURN_LOAD;
        end
        // DIR is only looked at once the dead time has fully elapsed
        TURN: begin
          if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
          else             state_d = dir_state;
        end
        default:  state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      reg_a   <= '0;
      reg_b   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (CAP_A) reg_a <= A;
      if (CAP_B) reg_b <= B;
    end
  end

  assign state   = state_q;
  assign b_drive = (state_q == DRIVE_AB);
  assign a_drive = (state_q == DRIVE_BA);

  // Source muxes stay combinational so SAB/SBA act without a clock edge
  assign B = b_drive ? (SAB ? reg_a : A) : {WIDTH{1'bz}};
  assign A = a_drive ? (SBA ? reg_b : B) : {WIDTH{1'bz}};

endmodule

// File: tb/tb_bus_transceiver_reg.sv
// tb/tb_bus_transceiver_reg.sv - directed and randomized checks of bus_transceiver_reg against a mode/dead-time model
module tb_bus_transceiver_reg;
  localparam int W = 8;
  localparam int T = 2;
  localparam int NSW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, oe_n, dir, cap_a, cap_b, sab, sba;
  logic [W-1:0] a_ext, b_ext;
  logic         a_ext_en, b_ext_en;
  wire  [W-1:0] a_bus, b_bus;
  logic [1:0]   state;
  logic         a_drive, b_drive;

  assign a_bus = a_ext_en ? a_ext : {W{1'bz}};
  assign b_bus = b_ext_en ? b_ext : {W{1'bz}};

  bus_transceiver_reg #(.WIDTH(W), .TURNAROUND(T), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .A(a_bus), .B(b_bus), .OE_n(oe_n), .DIR(dir),
    .CAP_A(cap_a), .CAP_B(cap_b), .SAB(sab), .SBA(sba),
    .state(state), .a_drive(a_drive), .b_drive(b_drive)
  );

  logic [1:0] sw_state [NSW];
  logic       sw_a [NSW];
  logic       sw_b [NSW];

  genvar g;
  generate
    for (g = 0; g < NSW; g++) begin : g_sweep
      localparam int SW = (g / 2 == 0) ? 1 : ((g / 2 == 1) ? 16 : 32);
      localparam int ST = (g % 2 == 0) ? 1 : 3;
      wire [SW-1:0] sa, sb;
      bus_transceiver_reg #(.WIDTH(SW), .TURNAROUND(ST), .CNT_W(4)) u_sw (
        .clk(clk), .reset(reset), .A(sa), .B(sb), .OE_n(oe_n), .DIR(dir),
        .CAP_A(1'b0), .CAP_B(1'b0), .SAB(1'b1), .SBA(1'b1),
        .state(sw_state[g]), .a_drive(sw_a[g]), .b_drive(sw_b[g])
      );
    end
  endgenerate

  // Model: mode 0 = nothing driven, 1 = A->B, 2 = B->A; dead = Z cycles still owed
  int           m_mode, m_dead;
  logic [W-1:0] m_ra, m_rb;
  int           s_mode [NSW];
  int           s_dead [NSW];
  logic         s_pa [NSW];
  logic         s_pb [NSW];
  logic         m_pa, m_pb;
  int           checks, errors;
  string        step;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s observed=%0h expected=%0h", step, tag, obs, exp);
    end
  endtask

  function automatic int sw_t(input int i);
    return (i % 2 == 0) ? 1 : 3;
  endfunction

  function automatic void fsm_step(input int tt, inout int mode, inout int dead);
    if (oe_n) begin
      mode = 0;
      dead = 0;
    end else if (dead > 0) begin
      if (dead > 1) dead--;
      else begin
        dead = 0;
        mode = dir ? 1 : 2;
      end
    end else if (mode == 0) begin
      mode = dir ? 1 : 2;
    end else if ((mode == 1) != dir) begin
      mode = 0;
      dead = tt;
    end
  endfunction

  function automatic int exp_state(input int mode, input int dead);
    return (dead > 0) ? 3 : mode;
  endfunction

  function automatic logic [W-1:0] exp_a();
    return (m_mode == 2) ? (sba ? m_rb : b_ext) : a_ext;
  endfunction

  function automatic logic [W-1:0] exp_b();
    return (m_mode == 1) ? (sab ? m_ra : a_ext) : b_ext;
  endfunction

  task automatic check_main();
    chk("state", {30'd0, state}, exp_state(m_mode, m_dead));
    chk("b_drive", {31'd0, b_drive}, {31'd0, m_mode == 1});
    chk("a_drive", {31'd0, a_drive}, {31'd0, m_mode == 2});
    chk("A", {24'd0, a_bus}, {24'd0, exp_a()});
    chk("B", {24'd0, b_bus}, {24'd0, exp_b()});
  endtask

  task automatic check_cycle();
    check_main();
    chk("main_overlap", {29'd0, a_drive & b_drive, a_drive & m_pb, b_drive & m_pa}, 32'd0);
    m_pa = a_drive;
    m_pb = b_drive;
    for (int i = 0; i < NSW; i++) begin
      chk($sformatf("sw%0d_state", i), {30'd0, sw_state[i]}, exp_state(s_mode[i], s_dead[i]));
      chk($sformatf("sw%0d_overlap", i),
          {29'd0, sw_a[i] & sw_b[i], sw_a[i] & s_pb[i], sw_b[i] & s_pa[i]}, 32'd0);
      s_pa[i] = sw_a[i];
      s_pb[i] = sw_b[i];
    end
  endtask

  task automatic tick();
    logic [W-1:0] pa, pb;
    int md, dd;
    pa = exp_a();
    pb = exp_b();
    @(posedge clk);
    if (reset) begin
      m_mode = 0; m_dead = 0; m_ra = '0; m_rb = '0;
      for (int i = 0; i < NSW; i++) begin s_mode[i] = 0; s_dead[i] = 0; end
    end else begin
      if (cap_a) m_ra = pa;
      if (cap_b) m_rb = pb;
      fsm_step(T, m_mode, m_dead);
      for (int i = 0; i < NSW; i++) begin
        md = s_mode[i]; dd = s_dead[i];
        fsm_step(sw_t(i), md, dd);
        s_mode[i] = md; s_dead[i] = dd;
      end
    end
    #1;
    a_ext_en = (m_mode != 2);
    b_ext_en = (m_mode != 1);
    #1;
    check_cycle();
  endtask

  task automatic settle();
    #1;
    check_main();
  endtask

  initial begin
    checks = 0; errors = 0;
    m_mode = 0; m_dead = 0; m_ra = '0; m_rb = '0; m_pa = 0; m_pb = 0;
    for (int i = 0; i < NSW; i++) begin
      s_mode[i] = 0; s_dead[i] = 0; s_pa[i] = 0; s_pb[i] = 0;
    end
    reset = 1; oe_n = 0; dir = 1; cap_a = 0; cap_b = 0; sab = 0; sba = 0;
    a_ext = 8'h5A; b_ext = 8'hC3; a_ext_en = 1; b_ext_en = 1;

    step = "reset";
    tick(); tick();
    chk("reset_state", {30'd0, state}, 32'd0);

    step = "release";
    reset = 0; sab = 1;
    tick();
    chk("reg_a_zero_on_B", {24'd0, b_bus}, 32'h00);
    sab = 0; settle();
    chk("live_after_reset", {24'd0, b_bus}, 32'h5A);

    step = "live";
    a_ext = 8'hA5; settle();
    chk("live_a5", {24'd0, b_bus}, 32'hA5);
    a_ext = 8'h3C; settle();
    chk("live_3c", {24'd0, b_bus}, 32'h3C);

    step = "reverse";
    dir = 0; b_ext = 8'h5A;
    tick(); chk("turn1", {30'd0, state}, 32'd3);
    tick(); chk("turn2", {30'd0, state}, 32'd3);
    tick(); chk("ba_after", {30'd0, state}, 32'd2);
    chk("ba_value", {24'd0, a_bus}, 32'h5A);

    step = "stored";
    dir = 1; tick(); tick(); tick();
    a_ext = 8'h11; cap_a = 1; tick();
    cap_a = 0; a_ext = 8'hFF; sab = 1; settle();
    chk("stored_b", {24'd0, b_bus}, 32'h11);
    dir = 0; tick(); tick(); tick();
    b_ext = 8'h22; cap_b = 1; tick();
    cap_b = 0; sba = 1; b_ext = 8'h33; settle();
    chk("stored_a", {24'd0, a_bus}, 32'h22);

    step = "bounce";
    dir = 1; tick(); dir = 0; tick(); dir = 1; tick();
    chk("bounce_end", {30'd0, state}, 32'd1);

    step = "abort";
    dir = 0; tick();
    oe_n = 1; tick();
    chk("abort_idle", {30'd0, state}, 32'd0);
    oe_n = 0; tick();
    chk("abort_enable", {30'd0, state}, 32'd2);

    step = "reset_turn";
    dir = 1; tick();
    reset = 1; tick();
    chk("reset_turn_idle", {30'd0, state}, 32'd0);
    reset = 0; tick();
    chk("reset_turn_drive", {30'd0, state}, 32'd1);

    step = "random";
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      oe_n  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) dir = ~dir;
      cap_a = $urandom_range(0, 1);
      cap_b = $urandom_range(0, 1);
      sab   = $urandom_range(0, 1);
      sba   = $urandom_range(0, 1);
      a_ext = W'($urandom);
      b_ext = W'($urandom);
      settle();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_transceiver_reg.md
# bus_transceiver_reg

Parametrised, clocked bus transceiver with storage registers: a wide successor to the octal 245-style transceiver, in the spirit of the 74LS652 registered transceiver. Two bidirectional buses A and B are joined under OE/DIR control. Each side has a capture register, and the driven output can be either the live opposite bus or the stored value. A turnaround state machine guarantees dead cycles with both sides released before the driving direction reverses, so the machine's shared data buses never see driver contention.

## Interface
- WIDTH, 8: bus width in bits (≥1).
- TURNAROUND, 1: dead cycles with both buses at Z on a direction reversal (≥1; 0 is illegal).
- CNT_W, 4: width of the turnaround counter; must satisfy TURNAROUND < 2^CNT_W.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- A  inout  WIDTH  bus A.
- B  inout  WIDTH  bus B.
- OE_n  input  1  output enable, active low; sampled on clk.
- DIR  input  1  direction: 1 = A to B, 0 = B to A; sampled on clk.
- CAP_A  input  1  on a clk edge, load reg_a from A.
- CAP_B  input  1  on a clk edge, load reg_b from B.
- SAB  input  1  source for B: 0 = live A, 1 = reg_a.
- SBA  input  1  source for A: 0 = live B, 1 = reg_b.
- state  output  2  0 = IDLE, 1 = DRIVE_AB, 2 = DRIVE_BA, 3 = TURN.
- a_drive  output  1  high while A is being driven (registered).
- b_drive  output  1  high while B is being driven (registered).

## Operation
- Reset values: state = IDLE; a_drive = b_drive = 0; A = B = Z; reg_a = reg_b = 0; turnaround counter = 0.
- Reset takes priority over every other input on the same edge, including mid-TURN or while driving. Both buses release after that edge.
- Bus drive:
  - B = b_drive ? (SAB ? reg_a : A) : Z.
  - A = a_drive ? (SBA ? reg_b : B) : Z.
  - Source selection is combinational, so SAB and SBA take effect without waiting for a clock edge.
- Drive enables decode from the state register: b_drive = (state == DRIVE_AB); a_drive = (state == DRIVE_BA).
- Transitions, evaluated on each edge with reset low:
  - Any state with OE_n = 1 → IDLE.
  - IDLE with OE_n = 0 → DRIVE_AB if DIR = 1, otherwise DRIVE_BA. No dead cycle is needed because nothing is driving.
  - DRIVE_AB with DIR = 0, or DRIVE_BA with DIR = 1 → TURN; counter loads TURNAROUND−1.
  - DRIVE_x with DIR unchanged → stay.
  - TURN with counter ≠ 0 → decrement and stay. DIR changes during TURN are ignored.
  - TURN with counter = 0 → DRIVE_AB or DRIVE_BA according to DIR sampled on that edge. This includes a return to the original direction if DIR toggled back.
- Capture registers:
  - reg_a ← A when CAP_A = 1; reg_b ← B when CAP_B = 1.
  - Capture happens independently of state, including while that side is being driven (the driven value is captured).
  - CAP_A and CAP_B on the same edge both load.
  - A Z or X bus value is stored as sampled; this is not filtered.
- Internal store-and-forward path: CAP_A in DRIVE_AB with SAB = 1 shows the new reg_a on B after the capturing edge.

## Timing
- Enable latency: OE_n falls before edge k → the bus is driven after edge k (1 cycle).
- Disable latency: OE_n rises before edge k → Z after edge k (1 cycle).
- Reversal: DIR changes before edge k while driving → Z after edge k.
  - Both buses stay at Z for exactly TURNAROUND cycles.
  - The new side is driven after edge k+TURNAROUND.
- OE_n = 1 during TURN aborts to IDLE on that edge. A later OE_n = 0 then enables with 1-cycle latency and no dead cycle.
- Registers update on the edge; the stored-source output reflects the new value in the same cycle after that edge.
- Simulation-only propagation delays are not modelled in this block; board-level delay belongs to the TTL models.

## Test plan
- Reset: drive reset = 1 with OE_n = 0 and DIR = 1 for 2 edges.
  - Required: state = 0, A = B = Z, reg_a = reg_b = 0.
  - Then release reset: B = A after 1 edge.
- Live pass-through, WIDTH = 8: OE_n = 0, DIR = 1, A = 0xA5.
  - Required: after 1 edge, b_drive = 1, B = 0xA5.
  - Set A = 0x3C: B = 0x3C with no further edge.
- Reversal with TURNAROUND = 2: from DRIVE_AB, DIR → 0, B externally 0x5A.
  - Required: edges 1–2 give state = 3 with A and B both Z.
  - After edge 3: state = 2, A = 0x5A.
- Stored mode: A = 0x11, pulse CAP_A, then A = 0xFF, SAB = 1, DRIVE_AB.
  - Required: B = 0x11.
  - Pulse CAP_B with B externally 0x22 while in DRIVE_BA, SBA = 1: A = 0x22.
- Abort and bounce:
  - DIR toggles 1→0→1 inside TURN: ends in DRIVE_AB.
  - OE_n = 1 mid-TURN: IDLE next edge, both Z.
  - Reset asserted mid-TURN: IDLE, counter cleared.
- Parameter sweep: WIDTH = 1, 16, 32 with TURNAROUND = 1, 3.
  - Required: a_drive & b_drive is never 1.
  - A driver and B driver are never active in the same cycle or in adjacent cycles across any reversal.
